// File: rtl/ifetch_queue_pkg.sv
// Shared RV32I fetch definitions: widths, NOP encoding,
// default reset PC and the {pc, instr} queue entry layout.
package ifetch_queue_pkg;

    localparam int          XLEN             = 32;
    localparam int          ILEN             = 32;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] align_pc(
        input logic [XLEN-1:0] pc
    );
        return {pc[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/ifetch_queue_if.sv
// Fetch-side bundle: instruction memory port, redirect
// request and the valid/ready handshake towards decode.
interface ifetch_queue_if;
    import ifetch_queue_pkg::*;

    logic [XLEN-1:0] imem_addr;
    logic [ILEN-1:0] imem_data;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            if_valid;
    logic            if_ready;
    logic [ILEN-1:0] if_instr;
    logic [XLEN-1:0] if_pc;

    modport master (
        output imem_addr,
        input  imem_data,
        input  redirect_valid,
        input  redirect_pc,
        output if_valid,
        input  if_ready,
        output if_instr,
        output if_pc
    );

    modport slave (
        input  imem_addr,
        output imem_data,
        output redirect_valid,
        output redirect_pc,
        input  if_valid,
        output if_ready,
        input  if_instr,
        input  if_pc
    );

endinterface

// File: rtl/ifetch_queue_fetch_fifo.sv
// Generic synchronous FIFO with flush; a push is accepted
// when full only if a pop retires the head in the same cycle.
module fetch_fifo #(
    parameter  int WIDTH = 64,
    parameter  int DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;
    logic             inc, dec;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];

    assign do_pop  = pop && !empty;
    assign do_push = push && !flush && (!full || do_pop);
    assign inc     = do_push && !do_pop;
    assign dec     = do_pop && !do_push && !flush;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        end
        unique case (1'b1)
            flush:   count_d = '0;
            inc:     count_d = count_q + CW'(1);
            dec:     count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage is never read while empty, so it is left unreset.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/ifetch_queue.sv
// Fetch stage: owns the fetch PC, captures memory words into a
// prefetch queue and hands them to decode; redirect flushes all.
module ifetch_queue
    import ifetch_queue_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic          clk,
    input  logic          rst_n,
    ifetch_queue_if.master bus
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int EW = $bits(fetch_entry_t);

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    fetch_entry_t    wr_entry;
    fetch_entry_t    head;
    logic [EW-1:0]   head_raw;
    logic [CW-1:0]   fifo_count;
    logic            fifo_full;
    logic            fifo_empty;
    logic            pop;
    logic            push;
    logic            redirect;

    assign redirect      = bus.redirect_valid;
    assign bus.imem_addr = fetch_pc_q;

    assign pop  = !fifo_empty && bus.if_ready;
    assign push = !redirect && (!fifo_full || pop);

    assign wr_entry = '{pc: fetch_pc_q, instr: bus.imem_data};
    assign head     = fetch_entry_t'(head_raw);

    fetch_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (redirect),
        .wdata (wr_entry),
        .rdata (head_raw),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        unique case (1'b1)
            redirect: fetch_pc_d = align_pc(bus.redirect_pc);
            push:     fetch_pc_d = fetch_pc_q + XLEN'(4);
            default:  fetch_pc_d = fetch_pc_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) fetch_pc_q <= RESET_PC;
        else        fetch_pc_q <= fetch_pc_d;
    end

    // Empty queue shows a NOP at pc 0 so decode never sees stale data.
    always_comb begin
        bus.if_valid = (fifo_count != '0);
        bus.if_instr = NOP_INSTR;
        bus.if_pc    = '0;
        if (bus.if_valid) begin
            bus.if_instr = head.instr;
            bus.if_pc    = head.pc;
        end
    end

endmodule

// File: tb/tb_ifetch_queue.sv
// Randomised scoreboard bench for ifetch_queue against a
// queue-level reference model of the fetch stage.
module tb_ifetch_queue;

    localparam int          DEPTH = 4;
    localparam logic [31:0] RPC   = 32'h0000_0000;
    localparam logic [31:0] RPC2  = 32'hFFFF_FFF8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    ifetch_queue_if bus ();
    ifetch_queue_if bus2 ();

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a >> 2;
    endfunction

    assign bus.imem_data  = mem_word(bus.imem_addr);
    assign bus2.imem_data = mem_word(bus2.imem_addr);

    ifetch_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (RPC)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    ifetch_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (RPC2)
    ) u_dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    int n_cmp = 0;
    int n_err = 0;

    logic [63:0] exp_q [$];
    logic [31:0] mpc;
    int          mcnt;

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h @%0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mpc  = RPC;
        mcnt = 0;
        exp_q.delete();
    endtask

    // One cycle, called right at a negedge.
    task automatic cycle(input logic rdy,
                         input logic rv,
                         input logic [31:0] rp);
        bit pop;
        bus.if_ready       = rdy;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rp;
        #1;
        chk("imem_addr", bus.imem_addr, mpc);
        chk("if_valid", {31'b0, bus.if_valid}, 32'(mcnt != 0));
        if (mcnt == 0) begin
            chk("empty_instr", bus.if_instr, 32'h0000_0013);
            chk("empty_pc", bus.if_pc, 32'h0);
        end
        #2;
        pop = (mcnt != 0) && rdy;
        if (rv) begin
            mpc  = {rp[31:2], 2'b00};
            mcnt = 0;
            exp_q.delete();
        end else if (mcnt < DEPTH || pop) begin
            exp_q.push_back({mpc, mem_word(mpc)});
            mpc = mpc + 32'd4;
            if (!pop) mcnt++;
        end
    endtask

    task automatic step(input logic rdy,
                        input logic rv,
                        input logic [31:0] rp);
        @(negedge clk);
        cycle(rdy, rv, rp);
    endtask

    task automatic async_reset(input logic rdy_after);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_if_valid", {31'b0, bus.if_valid}, 32'h0);
        chk("rst_if_instr", bus.if_instr, 32'h0000_0013);
        chk("rst_if_pc", bus.if_pc, 32'h0);
        chk("rst_imem_addr", bus.imem_addr, RPC);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        cycle(rdy_after, 1'b0, 32'h0);
    endtask

    // Monitor: compare every handshake against the scoreboard.
    initial begin
        logic [63:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && bus.if_valid && bus.if_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_delivery: got pc %h expected none",
                             bus.if_pc);
                end else begin
                    e = exp_q.pop_front();
                    chk("if_pc", bus.if_pc, e[63:32]);
                    chk("if_instr", bus.if_instr, e[31:0]);
                end
            end
        end
    end

    // Second instance: PC wrap from the top of the address space.
    initial begin
        logic [31:0] pcs [3];
        pcs[0] = 32'hFFFF_FFF8;
        pcs[1] = 32'hFFFF_FFFC;
        pcs[2] = 32'h0000_0000;
        bus2.if_ready       = 1'b1;
        bus2.redirect_valid = 1'b0;
        bus2.redirect_pc    = 32'h0;
        @(posedge rst_n);
        #1;
        chk("wrap_imem_addr", bus2.imem_addr, RPC2);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            chk("wrap_valid", {31'b0, bus2.if_valid}, 32'h1);
            chk("wrap_pc", bus2.if_pc, pcs[k]);
            chk("wrap_instr", bus2.if_instr, mem_word(pcs[k]));
        end
    end

    initial begin
        bus.if_ready       = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b1, 1'b0, 32'h0);

        repeat (10) step(1'b1, 1'b0, 32'h0);

        repeat (6) step(1'b0, 1'b0, 32'h0);
        async_reset(1'b0);
        repeat (7) step(1'b0, 1'b0, 32'h0);
        repeat (8) step(1'b1, 1'b0, 32'h0);

        repeat (2) step(1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b1, 32'h0000_0102);
        repeat (4) step(1'b1, 1'b0, 32'h0);

        for (int ph = 0; ph < 4; ph++) begin
            for (int i = 0; i < 200; i++) begin
                logic rdy;
                logic rv;
                rdy = ($urandom_range(0, 3) < ph + 1);
                rv  = ($urandom_range(0, 24) == 0);
                step(rdy, rv, $urandom);
            end
        end

        step(1'b1, 1'b1, 32'hFFFF_FFF3);
        repeat (6) step(1'b1, 1'b0, 32'h0);
        repeat (5) step(1'b0, 1'b0, 32'h0);
        repeat (6) step(1'b1, 1'b0, 32'h0);

        repeat (5) step(1'b0, 1'b0, 32'h0);
        async_reset(1'b1);
        repeat (8) step(1'b1, 1'b0, 32'h0);

        @(negedge clk);
        #5;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ifetch_queue.md
# ifetch_queue

Instruction fetch stage with a small prefetch queue, sitting directly upstream of the combinational instruction memory and downstream of the branch/jump resolution logic. It owns the fetch PC, drives the instruction-memory word address every cycle, captures the returned word together with its PC into a FIFO, and presents instructions to decode over a valid/ready handshake. A redirect flushes all prefetched work and restarts fetch at a new PC.

## Interface
- `DEPTH`, 4, queue entries; power of two, ≥2
- `RESET_PC`, 32'h0000_0000, fetch PC after reset
- `clk`  input  1  single clock, all state on rising edge
- `rst_n`  input  1  asynchronous, active-low reset
- `imem_addr`  output  32  byte address to instruction memory (equals fetch PC, bits [1:0] always 0)
- `imem_data`  input  32  instruction word, combinationally valid in the same cycle as `imem_addr`
- `redirect_valid`  input  1  flush queue and restart fetch
- `redirect_pc`  input  32  restart address; bits [1:0] ignored (forced to 0)
- `if_valid`  output  1  queue head valid
- `if_ready`  input  1  decode accepts head this cycle
- `if_instr`  output  32  head instruction
- `if_pc`  output  32  PC of head instruction

## Operation
- State: `fetch_pc` (32b), read pointer, write pointer, occupancy count (0..DEPTH), storage of DEPTH × {pc, instr} (64b).
- `imem_addr = fetch_pc` combinationally; no other memory control.
- pop = `if_valid && if_ready`.
- push = `!redirect_valid && (count < DEPTH || pop)`; on push, store {fetch_pc, imem_data} at write pointer, `fetch_pc <= fetch_pc + 4`.
- Redirect (highest priority): count, pointers cleared; `fetch_pc <= {redirect_pc[31:2], 2'b00}`; no push that cycle. A pop in the same cycle still counts as accepted by decode; the queue is cleared regardless.
- `if_valid = (count != 0)`; when empty, `if_instr = 32'h0000_0013` (NOP), `if_pc = 0`; when valid, head entry.
- Head entry and `if_valid` stay stable while `if_valid && !if_ready` (no redirect).
- Arithmetic: `fetch_pc + 4` modulo 2^32 (32'hFFFF_FFFC → 0); pointers modulo DEPTH.

## Timing
- Reset (async assert, any cycle, including mid-operation): `fetch_pc = RESET_PC`, `imem_addr = RESET_PC`, count 0, `if_valid = 0`, `if_instr = 32'h13`, `if_pc = 0`. Storage contents need not be reset.
- Fetch-to-decode latency: word at `imem_addr` in cycle N is presented at `if_*` in cycle N+1 (no empty-queue bypass).
- First cycle after reset release: push of RESET_PC; `if_valid` rises the following cycle.
- Redirect in cycle N: `if_valid = 0` in N+1, `imem_addr = redirect_pc` in N+1, redirect target instruction valid in N+2.
- Full and pop in same cycle: push proceeds, count unchanged, fetch_pc advances.
- Full without pop: no push, `fetch_pc` holds, `imem_addr` holds.
- Empty with `if_ready = 1`: no pop, no underflow.
- Steady state with `if_ready` held high: one instruction per cycle, sequential PCs.

## Structure
- Shared defines (rv32i defines include): NOP encoding 32'h0000_0013, instruction width, default reset PC.
- One sub-module: `fetch_fifo`, a generic synchronous FIFO (parameter width, depth; push/pop/flush, count, full/empty) instantiated with width 64; `ifetch_queue` keeps fetch PC and push/redirect control.

## Test plan
- Reset then `if_ready = 1`, memory word[i] = i: `if_valid` rises cycle 2 after release; `if_pc` = 0,4,8,… with `if_instr` = 0,1,2,… one per cycle.
- `if_ready = 0` from reset, DEPTH=4: exactly 4 pushes, `imem_addr` stalls at 0x10, head held at pc 0; raise `if_ready`: pcs 0,4,8,C,10 consecutive, no gaps or duplicates.
- Redirect to 0x0000_0102 while queue holds 3 entries and pop asserted: next cycle `if_valid = 0`, `imem_addr = 0x100`; following cycle `if_pc = 0x100`.
- `RESET_PC = 32'hFFFF_FFF8`, `if_ready = 1`: `if_pc` sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
- Assert `rst_n = 0` mid-stream with full queue: outputs immediately `if_valid = 0`, `if_instr = 0x13`, `imem_addr = RESET_PC`, asynchronously before next edge.
- Random `if_ready` toggling vs. scoreboard: every delivered {pc, instr} matches memory, strict PC order, no loss when full and pop coincide.
